// File: rtl/dram_access_controller.sv
// Frame sequencer for the shared data RAM: LOAD from UART Rx, hand to the processor (RUN),
// then stream the result window to UART Tx (DUMP) and park in DONE until reset.
//  state    | meaning
//  PH_LOAD  | rx bytes written to RAM at wr_ptr
//  PH_RUN   | processor drives RAM directly
//  PH_DUMP  | RD -> WT -> TX per result byte
//  PH_DONE  | idle until reset
module dram_access_controller #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int IMG_WORDS = 65536,
  parameter int OUT_BASE  = 0,
  parameter int OUT_WORDS = 16384
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_done,
  output logic              cpu_start,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic              dram_we,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic [1:0]        phase,
  output logic              rx_drop
);

  localparam logic [1:0] PH_LOAD = 2'b00;
  localparam logic [1:0] PH_RUN  = 2'b01;
  localparam logic [1:0] PH_DUMP = 2'b10;
  localparam logic [1:0] PH_DONE = 2'b11;

  localparam logic [1:0] SUB_RD = 2'b00;
  localparam logic [1:0] SUB_WT = 2'b01;
  localparam logic [1:0] SUB_TX = 2'b10;

  // Last-index compares keep a full 2^ADDR_W frame from needing an extra counter bit.
  localparam logic [ADDR_W-1:0] IMG_LAST  = ADDR_W'(IMG_WORDS - 1);
  localparam logic [ADDR_W-1:0] OUT_LAST  = ADDR_W'(OUT_WORDS - 1);
  localparam logic [ADDR_W-1:0] OUT_FIRST = ADDR_W'(OUT_BASE);

  logic [1:0]        phase_q, phase_d;
  logic [1:0]        sub_q, sub_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
  logic              load_last_q, load_last_d;
  logic              ld_we_q, ld_we_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [DATA_W-1:0] ld_wdata_q, ld_wdata_d;
  logic              cpu_start_q, cpu_start_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              rx_drop_q, rx_drop_d;

  always_comb begin
    phase_d     = phase_q;
    sub_d       = sub_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_cnt_d   = out_cnt_q;
    load_last_d = load_last_q;
    ld_we_d     = 1'b0;
    ld_addr_d   = ld_addr_q;
    ld_wdata_d  = ld_wdata_q;
    cpu_start_d = 1'b0;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    rx_drop_d   = rx_drop_q;

    // The cycle after the final LOAD strobe is already closed to new bytes.
    if (rx_valid && (phase_q != PH_LOAD || load_last_q)) rx_drop_d = 1'b1;

    case (phase_q)
      PH_LOAD: begin
        if (load_last_q) begin
          phase_d     = PH_RUN;
          cpu_start_d = 1'b1;
          load_last_d = 1'b0;
        end else if (rx_valid) begin
          ld_we_d    = 1'b1;
          ld_addr_d  = wr_ptr_q;
          ld_wdata_d = rx_data;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          if (wr_ptr_q == IMG_LAST) load_last_d = 1'b1;
        end
      end
      PH_RUN: begin
        if (cpu_done) begin
          phase_d = PH_DUMP;
          sub_d   = SUB_RD;
        end
      end
      PH_DUMP: begin
        case (sub_q)
          SUB_RD: sub_d = SUB_WT;
          SUB_WT: begin
            tx_data_d  = dram_rdata;
            tx_valid_d = 1'b1;
            sub_d      = SUB_TX;
          end
          SUB_TX: begin
            if (tx_ready) begin
              tx_valid_d = 1'b0;
              rd_ptr_d   = rd_ptr_q + 1'b1;
              out_cnt_d  = out_cnt_q + 1'b1;
              if (out_cnt_q == OUT_LAST) begin
                phase_d   = PH_DONE;
                tx_data_d = '0;
              end else begin
                sub_d = SUB_RD;
              end
            end
          end
          default: sub_d = SUB_RD;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    dram_addr  = '0;
    dram_wdata = '0;
    dram_we    = 1'b0;
    case (phase_q)
      PH_LOAD: begin
        dram_addr  = ld_addr_q;
        dram_wdata = ld_wdata_q;
        dram_we    = ld_we_q;
      end
      PH_RUN: begin
        dram_addr  = cpu_addr;
        dram_wdata = cpu_wdata;
        dram_we    = cpu_we;
      end
      PH_DUMP: dram_addr = rd_ptr_q;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase_q     <= PH_LOAD;
      sub_q       <= SUB_RD;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= OUT_FIRST;
      out_cnt_q   <= '0;
      load_last_q <= 1'b0;
      ld_we_q     <= 1'b0;
      ld_addr_q   <= '0;
      ld_wdata_q  <= '0;
      cpu_start_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      rx_drop_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      sub_q       <= sub_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_cnt_q   <= out_cnt_d;
      load_last_q <= load_last_d;
      ld_we_q     <= ld_we_d;
      ld_addr_q   <= ld_addr_d;
      ld_wdata_q  <= ld_wdata_d;
      cpu_start_q <= cpu_start_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      rx_drop_q   <= rx_drop_d;
    end
  end

  assign cpu_start = cpu_start_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign phase     = phase_q;
  assign rx_drop   = rx_drop_q;

endmodule

// File: tb/tb_dram_access_controller.sv
// Bench for dram_access_controller: small frame (4 bytes in, 2 bytes out from address 2)
// with a behavioural single-port RAM and queue-based expectations for writes and Tx bytes.
module tb_dram_access_controller;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_done;
  logic              cpu_start;
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_wdata;
  logic              dram_we;
  logic [DATA_W-1:0] dram_rdata = '0;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic [1:0]        phase;
  logic              rx_drop;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t         wr_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  mem [0:255];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (dram_we) mem[dram_addr[7:0]] <= dram_wdata;
    dram_rdata <= mem[dram_addr[7:0]];
  end

  dram_access_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMG_WORDS(4), .OUT_BASE(2), .OUT_WORDS(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_done(cpu_done),
    .cpu_start(cpu_start), .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we),
    .dram_rdata(dram_rdata), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .phase(phase), .rx_drop(rx_drop)
  );

  task automatic test_reset();
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = '0; cpu_addr = '0; cpu_wdata = '0;
    cpu_we = 1'b0; cpu_done = 1'b0; tx_ready = 1'b0;
    wr_q.delete(); tx_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({phase, cpu_start, dram_we, dram_addr, dram_wdata, tx_valid, tx_data} !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs phase=%b start=%b we=%b addr=%h wdata=%h txv=%b txd=%h want all zero",
               phase, cpu_start, dram_we, dram_addr, dram_wdata, tx_valid, tx_data);
    end
    checks++;
    if (rx_drop !== 1'b0) begin
      failures++; $display("FAIL reset_rx_drop got=%b want=0", rx_drop);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input bit extra);
    logic [7:0] bytes [4];
    int nwr = 0;
    int npulse = 0;
    int pulse_c = -1;
    wr_t e;
    bytes = '{b0, b1, b2, b3};
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      rx_valid = (c < 4) || (extra && c == 4);
      rx_data  = (c < 4) ? bytes[c] : 8'hEE;
      if (c < 4) wr_q.push_back(wr_t'{16'(c), bytes[c]});
      @(negedge clock);
      if (dram_we === 1'b1 && phase === 2'b00) begin
        nwr++;
        checks++;
        if (wr_q.size() == 0) begin
          failures++; $display("FAIL load_unexpected_write addr=%h data=%h", dram_addr, dram_wdata);
        end else begin
          e = wr_q.pop_front();
          if ({dram_addr, dram_wdata} !== {e.addr, e.data}) begin
            failures++;
            $display("FAIL load_write addr=%h data=%h want addr=%h data=%h",
                     dram_addr, dram_wdata, e.addr, e.data);
          end
        end
      end
      if (cpu_start === 1'b1) begin npulse++; pulse_c = c; end
    end
    rx_valid = 1'b0;
    checks++;
    if (nwr != 4 || wr_q.size() != 0) begin
      failures++; $display("FAIL load_count writes=%0d pending=%0d want 4/0", nwr, wr_q.size());
    end
    checks++;
    if (npulse != 1 || pulse_c != 5) begin
      failures++; $display("FAIL cpu_start_pulse pulses=%0d at=%0d want 1 at 5", npulse, pulse_c);
    end
    checks++;
    if (phase !== 2'b01) begin
      failures++; $display("FAIL load_to_run phase=%b want 01", phase);
    end
    checks++;
    if (rx_drop !== extra) begin
      failures++; $display("FAIL load_rx_drop got=%b want=%b", rx_drop, extra);
    end
  endtask

  task automatic test_run(input bit drop_probe);
    @(posedge clock); #1;
    cpu_addr = 16'h0005; cpu_wdata = 8'hA5; cpu_we = 1'b1;
    #1;
    checks++;
    if ({dram_addr, dram_wdata, dram_we} !== {16'h0005, 8'hA5, 1'b1}) begin
      failures++;
      $display("FAIL run_passthrough addr=%h data=%h we=%b want 0005/a5/1", dram_addr, dram_wdata, dram_we);
    end
    @(posedge clock); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0009;
    #1;
    checks++;
    if ({dram_addr, dram_we} !== {16'h0009, 1'b0}) begin
      failures++; $display("FAIL run_passthrough_idle addr=%h we=%b want 0009/0", dram_addr, dram_we);
    end
    if (drop_probe) begin
      rx_valid = 1'b1; rx_data = 8'h77;
      @(posedge clock); #1;
      rx_valid = 1'b0;
      @(negedge clock);
      checks++;
      if ({rx_drop, phase, dram_we} !== {1'b1, 2'b01, 1'b0}) begin
        failures++;
        $display("FAIL run_rx_drop drop=%b phase=%b we=%b want 1/01/0", rx_drop, phase, dram_we);
      end
    end
  endtask

  task automatic enter_dump(input logic [7:0] e0, input logic [7:0] e1);
    tx_q.push_back(e0); tx_q.push_back(e1);
    @(posedge clock); #1;
    cpu_done = 1'b1;
    @(negedge clock);
    checks++;
    if (phase !== 2'b01) begin
      failures++; $display("FAIL dump_early phase=%b want 01", phase);
    end
    @(posedge clock); #1;
    cpu_we = 1'b1; cpu_addr = 16'h0002; cpu_wdata = 8'hFF;
    @(negedge clock);
    checks++;
    if ({phase, dram_we} !== {2'b10, 1'b0}) begin
      failures++; $display("FAIL dump_entry phase=%b we=%b want 10/0", phase, dram_we);
    end
  endtask

  task automatic test_dump_stall(input bit drop_exp);
    int stall = 0;
    int guard = 0;
    bit prev_hs = 1'b0;
    while (tx_q.size() > 0 && guard < 60) begin
      @(negedge clock);
      guard++;
      tx_ready = 1'b0;
      if (prev_hs) begin
        checks++;
        if (tx_valid !== 1'b0) begin
          failures++; $display("FAIL dump_valid_drop got=%b want=0", tx_valid);
        end
        prev_hs = 1'b0;
      end
      if (tx_valid === 1'b1) begin
        checks++;
        if (tx_data !== tx_q[0]) begin
          failures++; $display("FAIL dump_data stall=%0d got=%h want=%h", stall, tx_data, tx_q[0]);
        end
        if (stall < 5) stall++;
        else begin
          void'(tx_q.pop_front());
          tx_ready = 1'b1; stall = 0; prev_hs = 1'b1;
        end
      end
    end
    checks++;
    if (tx_q.size() != 0) begin
      failures++; $display("FAIL dump_timeout pending=%0d want 0", tx_q.size());
    end
    @(negedge clock);
    tx_ready = 1'b0;
    checks++;
    if ({phase, tx_valid, dram_we, rx_drop} !== {2'b11, 1'b0, 1'b0, drop_exp}) begin
      failures++;
      $display("FAIL dump_done phase=%b txv=%b we=%b drop=%b want 11/0/0/%b",
               phase, tx_valid, dram_we, rx_drop, drop_exp);
    end
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int pulses = 0;
    int gap_bad = 0;
    tx_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (tx_valid === 1'b1) begin
        pulses++;
        if (last >= 0 && c - last != 3) gap_bad++;
        last = c;
        checks++;
        if (tx_q.size() == 0) begin
          failures++; $display("FAIL b2b_extra_byte got=%h want none", tx_data);
        end else if (tx_data !== tx_q[0]) begin
          failures++; $display("FAIL b2b_data got=%h want=%h", tx_data, tx_q[0]);
          void'(tx_q.pop_front());
        end else void'(tx_q.pop_front());
      end
    end
    tx_ready = 1'b0;
    checks++;
    if (pulses != 2 || gap_bad != 0) begin
      failures++; $display("FAIL b2b_rate pulses=%0d bad_gaps=%0d want 2/0", pulses, gap_bad);
    end
    checks++;
    if (phase !== 2'b11) begin
      failures++; $display("FAIL b2b_done phase=%b want 11", phase);
    end
  endtask

  task automatic test_reset_mid_dump();
    int guard = 0;
    tx_ready = 1'b0;
    do begin
      @(negedge clock);
      guard++;
    end while (tx_valid !== 1'b1 && guard < 10);
    checks++;
    if (tx_valid !== 1'b1) begin
      failures++; $display("FAIL mid_dump_timeout txv=%b want 1", tx_valid);
    end
    tx_ready = 1'b1; reset_n = 1'b0; cpu_done = 1'b0; cpu_we = 1'b0;
    @(negedge clock);
    checks++;
    if ({phase, tx_valid, dram_we, cpu_start} !== 5'b0) begin
      failures++;
      $display("FAIL mid_dump_reset phase=%b txv=%b we=%b start=%b want all zero",
               phase, tx_valid, dram_we, cpu_start);
    end
    tx_ready = 1'b0;
    tx_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    test_run(1'b1);
    enter_dump(8'h33, 8'h44);
    test_dump_stall(1'b1);

    test_reset();
    test_load(8'h5A, 8'hC3, 8'h0F, 8'hF0, 1'b0);
    test_run(1'b0);
    enter_dump(8'h0F, 8'hF0);
    test_back_to_back();

    test_reset();
    test_load(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    test_run(1'b0);
    enter_dump(8'h03, 8'h04);
    test_reset_mid_dump();
    test_load(8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t want finish earlier", $time);
    $fatal(1, "timeout");
  end
endmodule
